mem_wb_stage: RTL



---
 rtl/mem_wb_stage_pkg.sv | 31 +++
 rtl/mem_wb_stage_mem2wb_reg.sv | 48 ++++
 rtl/mem_wb_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the MEM/WB stage of the 32-bit pipelined MIPS core:
//   - state_t      : MEM-stage handshake FSM encoding (IDLE / ACCESS)
//   - WB_REGWRITE  : index of RegWrite inside the 2-bit Wb control field
//   - WB_MEMTOREG  : index of MemtoReg inside the 2-bit Wb control field
//   - CORE_DATA_W  : default datapath / address width
//   - REG_IDX_W    : register-file index width
//   - wb_enable()  : register-file write enable with $0 suppression
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int CORE_DATA_W = 32;
   localparam int REG_IDX_W   = 5;

   // $0 is hard-wired to zero, so a write aimed at it must never reach the
   // register file.
   function automatic logic wb_enable(input logic regwrite,
                                      input logic [REG_IDX_W-1:0] rd);
      return regwrite && (rd != '0);
   endfunction

endpackage

// File: rtl/mem_wb_stage_mem2wb_reg.sv
// -----------------------------------------------------------------------------
// mem2wb_reg
// MEM/WB pipeline latch. Holds the register-file write port presented to ID.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears latch)
//   load              : capture in_* on this edge
//   bubble            : insert a bubble (RegWrite=0); has priority over load
//   in_regwrite       : incoming write enable (already $0-filtered)
//   in_write_register : incoming destination register
//   in_write_data     : incoming write data
//   regwrite          : registered write enable
//   write_register    : registered destination register
//   write_data        : registered write data
// With neither load nor bubble the latch holds its contents.
// -----------------------------------------------------------------------------
module mem2wb_reg
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = CORE_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 bubble,
   input  logic                 in_regwrite,
   input  logic [REG_IDX_W-1:0] in_write_register,
   input  logic [DATA_W-1:0]    in_write_data,
   output logic                 regwrite,
   output logic [REG_IDX_W-1:0] write_register,
   output logic [DATA_W-1:0]    write_data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite       <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
      end else if (bubble) begin
         // Only the enable matters for a bubble; the data fields are don't-care.
         regwrite <= 1'b0;
      end else if (load) begin
         regwrite       <= in_regwrite;
         write_register <= in_write_register;
         write_data     <= in_write_data;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM and WB stages of the 32-bit pipelined MIPS core (after the EX/MEM latch).
// Data-memory accesses use a req/ready handshake that tolerates multi-cycle
// memory; mem_stall freezes the upstream stages while an access is pending.
// The MEM/WB latch (mem2wb_reg) drives the register-file write port into ID.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   : adds parameter TIMEOUT_CYCLES and sticky output mem_error; an
//               access that sees no dmem_ready for TIMEOUT_CYCLES ACCESS cycles
//               is abandoned (req dropped, bubble loaded, stall released).
//   Undefined : ACCESS waits indefinitely for dmem_ready.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   Ex_Valid                 : EX/MEM slot holds a real instruction
//   Ex_Wb[1:0]               : {RegWrite, MemtoReg}
//   Ex_MemR / Ex_MemW        : load / store (both set = store)
//   Ex_ALU_Result            : ALU result, also the memory address
//   Ex_Store_Data            : store data (rt)
//   Ex_Write_Register        : destination register
//   dmem_req/we/addr/wdata   : memory request, held until dmem_ready
//   dmem_rdata, dmem_ready   : load data / access complete this cycle
//   mem_stall                : upstream must hold the EX/MEM slot
//   mem_error                : (MEM_TIMEOUT_EN only) sticky timeout flag
//   RegWrite, Write_Register,
//   Write_Data               : registered register-file write port to ID
// -----------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
`ifdef MEM_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 16,
`endif
   parameter int DATA_W = CORE_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Ex_Valid,
   input  logic [1:0]           Ex_Wb,
   input  logic                 Ex_MemR,
   input  logic                 Ex_MemW,
   input  logic [DATA_W-1:0]    Ex_ALU_Result,
   input  logic [DATA_W-1:0]    Ex_Store_Data,
   input  logic [REG_IDX_W-1:0] Ex_Write_Register,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [DATA_W-1:0]    dmem_addr,
   output logic [DATA_W-1:0]    dmem_wdata,
   input  logic [DATA_W-1:0]    dmem_rdata,
   input  logic                 dmem_ready,
   output logic                 mem_stall,
`ifdef MEM_TIMEOUT_EN
   output logic                 mem_error,
`endif
   output logic                 RegWrite,
   output logic [REG_IDX_W-1:0] Write_Register,
   output logic [DATA_W-1:0]    Write_Data
);

   state_t               state_p1;
   // Write-back controls of the instruction in flight, captured on entry to
   // ACCESS so the result does not depend on what EX/MEM shows meanwhile.
   logic [1:0]           wb_p1;
   logic [REG_IDX_W-1:0] rd_p1;

   logic                 mem_op;
   logic                 timeout_hit;
   logic                 wb_load;
   logic                 wb_regwrite_in;
   logic [REG_IDX_W-1:0] wb_rd_in;
   logic [DATA_W-1:0]    wb_data_in;

   assign mem_op = Ex_Valid & (Ex_MemR | Ex_MemW);

`ifdef MEM_TIMEOUT_EN
   localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYCLES - 1);
   logic [4:0] wait_cnt_p1;

   // Last permitted ACCESS cycle without ready: abandon at this edge.
   assign timeout_hit = (state_p1 == ACCESS) & ~dmem_ready & (wait_cnt_p1 == WAIT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Stall is combinational so the EX/MEM slot is frozen in the same cycle
   // the memory op is first seen; it releases in the cycle the access ends.
   always_comb begin
      mem_stall = 1'b0;
      case (state_p1)
         IDLE:    mem_stall = mem_op;
         ACCESS:  mem_stall = ~dmem_ready & ~timeout_hit;
         default: mem_stall = 1'b0;
      endcase
   end

   // MEM/WB latch input select: anything not loaded this edge is a bubble.
   always_comb begin
      wb_load        = 1'b0;
      wb_regwrite_in = 1'b0;
      wb_rd_in       = '0;
      wb_data_in     = '0;
      case (state_p1)
         IDLE: begin
            if (Ex_Valid && !mem_op) begin
               wb_load        = 1'b1;
               wb_regwrite_in = wb_enable(Ex_Wb[WB_REGWRITE], Ex_Write_Register);
               wb_rd_in       = Ex_Write_Register;
               wb_data_in     = Ex_ALU_Result;
            end
         end
         ACCESS: begin
            // Completed store produces no write-back; a completed load does.
            if (dmem_ready && !dmem_we) begin
               wb_load        = 1'b1;
               wb_regwrite_in = wb_enable(wb_p1[WB_REGWRITE], rd_p1);
               wb_rd_in       = rd_p1;
               wb_data_in     = wb_p1[WB_MEMTOREG] ? dmem_rdata : dmem_addr;
            end
         end
         default: ;
      endcase
   end

   // ---- MEM stage: handshake FSM and request registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1   <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_p1      <= '0;
         rd_p1      <= '0;
`ifdef MEM_TIMEOUT_EN
         wait_cnt_p1 <= '0;
         mem_error   <= 1'b0;
`endif
      end else begin
         case (state_p1)
            IDLE: begin
               if (mem_op) begin
                  state_p1   <= ACCESS;
                  dmem_req   <= 1'b1;
                  dmem_we    <= Ex_MemW;
                  dmem_addr  <= Ex_ALU_Result;
                  dmem_wdata <= Ex_Store_Data;
                  wb_p1      <= Ex_Wb;
                  rd_p1      <= Ex_Write_Register;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt_p1 <= '0;
`endif
               end
            end
            ACCESS: begin
               if (dmem_ready) begin
                  state_p1 <= IDLE;
                  dmem_req <= 1'b0;
               end
`ifdef MEM_TIMEOUT_EN
               else if (timeout_hit) begin
                  state_p1  <= IDLE;
                  dmem_req  <= 1'b0;
                  mem_error <= 1'b1;
               end else begin
                  wait_cnt_p1 <= wait_cnt_p1 + 5'd1;
               end
`endif
            end
            default: begin
               state_p1 <= IDLE;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

   // ---- WB stage: MEM/WB latch ----
   mem2wb_reg #(
      .DATA_W (DATA_W)
   ) u_mem2wb_reg (
      .clk               (clk),
      .rst               (rst),
      .load              (wb_load),
      .bubble            (~wb_load),
      .in_regwrite       (wb_regwrite_in),
      .in_write_register (wb_rd_in),
      .in_write_data     (wb_data_in),
      .regwrite          (RegWrite),
      .write_register    (Write_Register),
      .write_data        (Write_Data)
   );

endmodule
